// File: rtl/ecc_apb_master.sv
// ecc_apb_master
//   APB initiator that feeds register reads/writes to the ECC encoder/decoder.
//   Commands are queued in a small FIFO and played out as SETUP/ACCESS pairs.
//   The slave has no PREADY, so every ACCESS phase lasts exactly one cycle.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata        command payload
//   PADDR/PWDATA/PSEL/PENABLE/PWRITE  registered APB initiator outputs
//   PRDATA                      APB read data
//   rsp_valid/rsp_rdata         one-cycle read-completion pulse and held data
//   busy                        FIFO non-empty or transfer in progress
//
// state  | meaning
// IDLE   | no transfer; PSEL=0, bus payload holds last values
// SETUP  | PSEL=1, PENABLE=0, payload stable
// ACCESS | PSEL=1, PENABLE=1, read data sampled on the closing edge

module ecc_apb_master #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int CMD_DEPTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       busy
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMD_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_q;

  // command FIFO storage
  logic                       fifo_write_q [CMD_DEPTH];
  logic [AMBA_ADDR_WIDTH-1:0] fifo_addr_q  [CMD_DEPTH];
  logic [AMBA_WORD-1:0]       fifo_wdata_q [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic push;
  logic pop;
  logic fifo_nempty;

  logic                       head_write;
  logic [AMBA_ADDR_WIDTH-1:0] head_addr;
  logic [AMBA_WORD-1:0]       head_wdata;

  logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
  logic [AMBA_WORD-1:0]       pwdata_q;
  logic                       psel_q;
  logic                       penable_q;
  logic                       pwrite_q;
  logic                       rsp_valid_q;
  logic [AMBA_WORD-1:0]       rsp_rdata_q;

  assign fifo_nempty = (count_q != '0);

  // Readiness depends only on the registered count, so a pop in the same
  // cycle never frees a slot for a push while full.
  assign cmd_ready = !rst && (count_q != DEPTH_C);
  assign push      = cmd_valid && cmd_ready;

  // The head is consumed when a new SETUP is launched (from IDLE or ACCESS).
  assign pop = fifo_nempty && ((state_q == IDLE) || (state_q == ACCESS));

  assign head_write = fifo_write_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (fifo_nempty) begin
            state_q  <= SETUP;
            paddr_q  <= head_addr;
            pwdata_q <= head_wdata;
            pwrite_q <= head_write;
            psel_q   <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          psel_q    <= 1'b1;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (!pwrite_q) begin
            rsp_rdata_q <= PRDATA;
            rsp_valid_q <= 1'b1;
          end
          penable_q <= 1'b0;
          if (fifo_nempty) begin
            // back-to-back: straight into the next SETUP, PSEL stays high
            state_q  <= SETUP;
            paddr_q  <= head_addr;
            pwdata_q <= head_wdata;
            pwrite_q <= head_write;
            psel_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            psel_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE) || fifo_nempty;

endmodule

// File: tb/tb_ecc_apb_master.sv
module tb_ecc_apb_master;

  localparam int AW = 20;
  localparam int DW = 32;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PRDATA;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  xfer_t         exp_q[$];
  logic [DW-1:0] rsp_q[$];

  logic          prdata_fix_en = 1'b0;
  logic [DW-1:0] prdata_fix    = '0;

  ecc_apb_master #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .CMD_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRDATA(PRDATA), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Must be called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    cmd_valid = 1'b0;
    if (acc) exp_q.push_back('{w: w, a: a, d: d});
    else chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // PRDATA source: random each cycle unless a fixed value is requested.
  initial begin
    PRDATA = '0;
    forever begin
      @(posedge clk);
      #1;
      PRDATA = prdata_fix_en ? prdata_fix : $urandom;
    end
  end

  // Monitor: every ACCESS must match the oldest accepted command; every
  // rsp_valid must match the PRDATA seen in the oldest outstanding read.
  initial begin
    logic          prev_setup;
    logic [AW-1:0] prev_addr;
    xfer_t         e;
    prev_setup = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_setup = 1'b0;
      end else begin
        if (rsp_valid) begin
          if (rsp_q.size() == 0) chk("rsp_expected", 0, 1);
          else chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
        end
        if (PSEL && PENABLE) begin
          chk("setup_before_access", prev_setup, 1);
          chk("addr_stable", PADDR, prev_addr);
          if (exp_q.size() == 0) begin
            chk("xfer_expected", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_addr", PADDR, e.a);
            chk("xfer_write", PWRITE, e.w);
            if (e.w) chk("xfer_wdata", PWDATA, e.d);
            else rsp_q.push_back(PRDATA);
          end
        end
        prev_setup = PSEL && !PENABLE;
        prev_addr  = PADDR;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int            waits;
    logic [8:0]    psel_tr;
    logic [8:0]    pen_tr;
    int            n_psel;
    logic [AW-1:0] ra;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    #3;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // single write
    send(1'b1, 20'h00004, 32'hA5A5A5A5, waits);
    @(posedge clk);
    @(negedge clk);
    chk("wr_setup_psel", PSEL, 1);
    chk("wr_setup_pen", PENABLE, 0);
    chk("wr_setup_paddr", PADDR, 20'h00004);
    chk("wr_setup_pwdata", PWDATA, 32'hA5A5A5A5);
    chk("wr_setup_pwrite", PWRITE, 1);
    @(negedge clk);
    chk("wr_access_pen", PENABLE, 1);
    @(negedge clk);
    chk("wr_no_rsp", rsp_valid, 0);
    chk("wr_busy_low", busy, 0);
    chk("wr_psel_low", PSEL, 0);
    wait_idle();

    // single read with fixed PRDATA
    prdata_fix_en = 1'b1;
    prdata_fix    = 32'h12345678;
    send(1'b0, 20'h0000C, 32'h0, waits);
    @(posedge clk);
    @(negedge clk);
    chk("rd_setup", {PSEL, PENABLE, PWRITE}, 3'b100);
    chk("rd_setup_paddr", PADDR, 20'h0000C);
    @(negedge clk);
    chk("rd_access", {PSEL, PENABLE}, 2'b11);
    chk("rd_no_rsp_yet", rsp_valid, 0);
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    @(negedge clk);
    chk("rd_rsp_pulse_end", rsp_valid, 0);
    chk("rd_rsp_hold", rsp_rdata, 32'h12345678);
    prdata_fix_en = 1'b0;
    wait_idle();

    // back-to-back: W 0x0, W 0x4, R 0x8 on consecutive cycles
    fork
      begin
        send(1'b1, 20'h00000, $urandom, waits);
        send(1'b1, 20'h00004, $urandom, waits);
        send(1'b0, 20'h00008, 32'h0, waits);
        chk("b2b_ready_low", cmd_ready, 0);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          psel_tr[i] = PSEL;
          pen_tr[i]  = PENABLE;
        end
      end
    join
    chk("b2b_psel_trace", psel_tr, 9'b011111100);
    chk("b2b_pen_trace", pen_tr, 9'b010101000);
    wait_idle();

    // full FIFO: fourth command held until a slot frees
    send(1'b1, 20'h00010, $urandom, waits);
    send(1'b0, 20'h00014, 32'h0, waits);
    send(1'b1, 20'h00018, $urandom, waits);
    send(1'b0, 20'h0001C, 32'h0, waits);
    chk("full_wait_cycles", waits, 1);
    wait_idle();

    // reset during ACCESS with one command queued
    send(1'b1, 20'h00020, $urandom, waits);
    send(1'b1, 20'h00024, $urandom, waits);
    @(posedge clk);
    #2;
    chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_pen", PENABLE, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    exp_q.delete();
    rsp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_psel = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (PSEL || rsp_valid || busy) n_psel++;
    end
    chk("post_rst_quiet", n_psel, 0);
    @(posedge clk);
    #1;

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      ra = AW'($urandom) & ~AW'(3);
      send(1'($urandom), ra, $urandom, waits);
    end
    wait_idle();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_apb_master.md
ECC_APB_MASTER -- requirements
Module: ecc_apb_master

Interface
REQ-001 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-002 SHALL have parameter AMBA_WORD, default 32, APB data width.
REQ-003 SHALL have parameter CMD_DEPTH, default 2, command FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-009 SHALL have port cmd_addr  input  AMBA_ADDR_WIDTH  target register address.
REQ-010 SHALL have port cmd_wdata  input  AMBA_WORD  write data (ignored for reads).
REQ-011 SHALL have ports PADDR (AMBA_ADDR_WIDTH), PWDATA (AMBA_WORD), PSEL (1), PENABLE (1), PWRITE (1): outputs, APB initiator signals, all registered.
REQ-012 SHALL have port PRDATA  input  AMBA_WORD  APB read data from the ECC encoder/decoder.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle pulse, read data available.
REQ-014 SHALL have port rsp_rdata  output  AMBA_WORD  captured read data.
REQ-015 SHALL have port busy  output  1  FIFO non-empty or transfer in progress.

Function
REQ-016 SHALL buffer commands {write, addr, wdata} in a CMD_DEPTH-entry FIFO; cmd_ready = not full (combinational from count).
REQ-017 SHALL push when cmd_valid && cmd_ready; when full, a same-cycle pop SHALL NOT allow a push (cmd_ready stays low that cycle).
REQ-018 SHALL pop and push in the same cycle when not full; count unchanged; pointers wrap modulo CMD_DEPTH.
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS; the slave has no PREADY, so every ACCESS lasts exactly one cycle.
REQ-020 IDLE: PSEL=0, PENABLE=0; PADDR/PWDATA/PWRITE hold last values; if FIFO non-empty -> SETUP, popping the head and loading it into PADDR/PWDATA/PWRITE on that edge.
REQ-021 SETUP: PSEL=1, PENABLE=0, address/data/direction stable; unconditionally -> ACCESS.
REQ-022 ACCESS: PSEL=1, PENABLE=1; if FIFO non-empty -> SETUP with pop (back-to-back, no IDLE gap), else -> IDLE.
REQ-023 For reads, rsp_rdata SHALL capture PRDATA on the edge ending ACCESS and rsp_valid SHALL be high for exactly the following cycle; writes produce no rsp_valid.
REQ-024 rsp_rdata SHALL hold its value until the next read completes.
REQ-025 Latency: command accepted at edge N into empty FIFO in IDLE -> SETUP visible after edge N+1, ACCESS after N+2, rsp_valid after N+3.
REQ-026 Sustained throughput SHALL be one APB transfer per 2 cycles.
REQ-027 busy = (state != IDLE) || (count != 0).

Reset
REQ-028 rst high SHALL immediately force: state IDLE, FIFO empty, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, busy=0.
REQ-029 cmd_ready SHALL be 0 while rst is high.
REQ-030 Reset mid-transfer SHALL abort the transfer and discard queued commands; no rsp_valid issued for them.

Verification
REQ-031 Single write: cmd write addr 0x00004 data 0xA5A5A5A5 -> SETUP then ACCESS with PADDR=0x00004, PWDATA=0xA5A5A5A5, PWRITE=1; no rsp_valid; busy low after.
REQ-032 Single read: cmd read addr 0x0000C, PRDATA=0x12345678 during ACCESS -> rsp_valid pulse 3 cycles after accept, rsp_rdata=0x12345678.
REQ-033 Back-to-back: 3 commands (W 0x0, W 0x4, R 0x8) on consecutive cycles -> cmd_ready low after 2 queued, PSEL continuously high for 6 cycles, PENABLE toggles 0,1,0,1,0,1.
REQ-034 Full FIFO: 2 queued plus cmd_valid held -> third accepted only on first cycle count <2; order preserved.
REQ-035 Reset during ACCESS with 1 queued command -> PSEL/PENABLE 0 asynchronously, no rsp_valid, FIFO empty, no transfer after rst release until a new command.
